// File: rtl/input_port_buffer_if.sv
// Flit-side bundle between an upstream link, the input buffer and the output-port allocator.
// The buffer takes the slave view; the link/allocator side (or a bench) takes the master view.
interface input_port_buffer_if #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              grant;
   logic [2:0]        targ;
   logic [DATA_W-1:0] out_data;
   logic              empty;
   logic [CNT_W-1:0]  count;
   logic              credit_out;
   logic              err_overflow;

   modport master (
      output in_valid, in_data, grant,
      input  targ, out_data, empty, count, credit_out, err_overflow
   );

   modport slave (
      input  in_valid, in_data, grant,
      output targ, out_data, empty, count, credit_out, err_overflow
   );
endinterface

// File: rtl/input_port_buffer.sv
// Per-input-port flit FIFO with XY route lookup on the head flit and one upstream credit per pop.
// Head data and target are combinational from the head entry, so a new flit is visible one edge after its write.
module input_port_buffer #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   parameter int X_W    = 2,
   parameter int Y_W    = 2,
   parameter int CUR_X  = 0,
   parameter int CUR_Y  = 0
) (
   input  logic                clk,
   input  logic                rst,
   input_port_buffer_if.slave  bus
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [X_W-1:0]   HERE_X   = X_W'(CUR_X);
   localparam logic [Y_W-1:0]   HERE_Y   = Y_W'(CUR_Y);

   typedef enum logic [2:0] {
      TARG_NONE = 3'd0,
      TARG_N    = 3'd1,
      TARG_S    = 3'd2,
      TARG_E    = 3'd3,
      TARG_W    = 3'd4,
      TARG_PE   = 3'd5
   } targ_e;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              credit_q, err_q;

   logic              empty, full, pop, push;
   logic [DATA_W-1:0] head;
   logic [X_W-1:0]    dst_x;
   logic [Y_W-1:0]    dst_y;
   targ_e             targ_c;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   assign empty = (count == '0);
   assign full  = (count == CNT_FULL);
   // A grant on an empty buffer is ignored; a full buffer still accepts a write when it pops the same cycle.
   assign pop   = bus.grant && !empty;
   assign push  = bus.in_valid && (!full || pop);

   // Storage is deliberately not reset; occupancy is tracked by count alone.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.in_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         credit_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         credit_q <= pop;
         if (bus.in_valid && full && !pop) err_q <= 1'b1;
      end
   end

   // XY dimension-order routing: resolve X first, then Y, then eject locally.
   always_comb begin
      head   = mem[rd_ptr];
      dst_x  = head[DATA_W-1 -: X_W];
      dst_y  = head[DATA_W-1-X_W -: Y_W];
      targ_c = TARG_NONE;
      if (!empty) begin
         if (dst_x > HERE_X)      targ_c = TARG_E;
         else if (dst_x < HERE_X) targ_c = TARG_W;
         else if (dst_y > HERE_Y) targ_c = TARG_N;
         else if (dst_y < HERE_Y) targ_c = TARG_S;
         else                     targ_c = TARG_PE;
      end
   end

   assign bus.targ         = targ_c;
   assign bus.out_data     = head;
   assign bus.empty        = empty;
   assign bus.count        = count;
   assign bus.credit_out   = credit_q;
   assign bus.err_overflow = err_q;
endmodule

// File: tb/tb_input_port_buffer.sv
// Scoreboard bench for input_port_buffer at router (1,1): a queue model tracks expected occupancy,
// a separate negedge monitor checks state every cycle and compares each popped flit against the expected queue.
module tb_input_port_buffer;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;

   typedef struct packed {
      logic [31:0] d;
      logic [2:0]  t;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   input_port_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   input_port_buffer #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .X_W(2), .Y_W(2), .CUR_X(1), .CUR_Y(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   logic [31:0] mq[$];
   exp_t        exp_q[$];
   bit          m_credit, m_err, mon_en;
   int          n_chk, n_bad;

   function automatic logic [2:0] route(input logic [31:0] f);
      logic [1:0] x, y;
      x = f[31:30];
      y = f[29:28];
      if (x > 2'd1) return 3'd3;
      if (x < 2'd1) return 3'd4;
      if (y > 2'd1) return 3'd1;
      if (y < 2'd1) return 3'd2;
      return 3'd5;
   endfunction

   function automatic logic [31:0] mkflit(input int x, input int y);
      logic [31:0] r;
      logic [1:0]  xs, ys;
      r  = $urandom;
      xs = 2'(x);
      ys = 2'(y);
      return {xs, ys, r[27:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; the model advances to the post-edge state after the edge.
   task automatic step(input bit v, input logic [31:0] d, input bit g, input bit r);
      bit pop, push, full;
      bus.in_valid = v;
      bus.in_data  = d;
      bus.grant    = g;
      rst          = r;
      pop  = !r && g && (mq.size() != 0);
      full = (mq.size() == DEPTH);
      push = v && (!full || pop);
      if (pop) exp_q.push_back('{d: mq[0], t: route(mq[0])});
      @(posedge clk);
      #1;
      if (r) begin
         mq.delete();
         m_credit = 1'b0;
         m_err    = 1'b0;
      end else begin
         if (v && full && !pop) m_err = 1'b1;
         if (pop)  void'(mq.pop_front());
         if (push) mq.push_back(d);
         m_credit = pop;
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         chk("count", 32'(bus.count), 32'(mq.size()));
         chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
         chk("credit_out", 32'(bus.credit_out), 32'(m_credit));
         chk("err_overflow", 32'(bus.err_overflow), 32'(m_err));
         if (mq.size() == 0) chk("targ_empty", 32'(bus.targ), 32'd0);
         else begin
            chk("head_data", bus.out_data, mq[0]);
            chk("head_targ", 32'(bus.targ), 32'(route(mq[0])));
         end
         if (!rst && bus.grant && !bus.empty) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_bad++;
               $display("FAIL pop_unexpected: got pop of %0h expected no pop at %0t", bus.out_data, $time);
            end else begin
               e = exp_q.pop_front();
               chk("pop_data", bus.out_data, e.d);
               chk("pop_targ", 32'(bus.targ), 32'(e.t));
            end
         end
      end
   end

   initial begin
      int xs[5] = '{2, 0, 1, 1, 1};
      int ys[5] = '{0, 3, 2, 0, 1};
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.grant    = 1'b0;
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      mon_en = 1'b1;

      // reset mid-traffic with three flits queued
      for (int i = 0; i < 3; i++) step(1, mkflit(i % 4, i % 4), 0, 0);
      step(1, mkflit(3, 3), 1, 1);
      step(0, 0, 1, 1);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);

      // routing: E, W, N, S, PE
      for (int i = 0; i < 5; i++) begin
         step(1, mkflit(xs[i], ys[i]), 0, 0);
         step(0, 0, 1, 0);
      end
      step(0, 0, 0, 0);

      // fill, overflow drop, drain
      for (int i = 0; i < 5; i++) step(1, mkflit(i % 4, (i + 1) % 4), 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
      step(0, 0, 0, 1);

      // full with simultaneous push and grant
      for (int i = 0; i < 4; i++) step(1, mkflit(i % 4, 2), 0, 0);
      step(1, mkflit(3, 0), 1, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0);

      // credits: back-to-back grants, then grant while empty
      for (int i = 0; i < 3; i++) step(1, mkflit(1, i), 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);

      // empty with push and grant together: grant ignored, flit stored
      step(1, mkflit(0, 0), 1, 0);
      step(0, 0, 1, 0);

      // wrap with single-entry occupancy
      step(1, mkflit(2, 2), 0, 0);
      for (int i = 0; i < 9; i++) step(1, mkflit(i % 4, (i + 2) % 4), 1, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);

      // randomized traffic with occasional reset
      for (int i = 0; i < 600; i++) begin
         bit v, g, r;
         v = ($urandom_range(0, 99) < ((i < 300) ? 70 : 40));
         g = ($urandom_range(0, 99) < ((i < 300) ? 40 : 70));
         r = ($urandom_range(0, 149) == 0);
         step(v, mkflit($urandom_range(0, 3), $urandom_range(0, 3)), g, r);
      end
      for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
      step(0, 0, 0, 0);

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
